// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DBITS_MIN = 5;

  // Out-of-range data lengths are pulled into DBITS_MIN..max_bits rather than rejected.
  function automatic logic [3:0] clamp_dbits(input logic [3:0] cfg, input int max_bits);
    logic [3:0] res;
    res = cfg;
    if (cfg < 4'(DBITS_MIN)) res = 4'(DBITS_MIN);
    else if (cfg > 4'(max_bits)) res = 4'(max_bits);
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_bit_timer.sv
// uart_bit_timer: bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and pulses o_BIT_END on the terminal count. With i_LONG set the
// period is doubled by a half flag, so two stop bits never need a wider counter.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_CLR,
  input  logic i_LONG,
  output logic o_BIT_END
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_half;
  logic             w_tc;

  assign w_tc      = (r_cnt == TC);
  assign o_BIT_END = w_tc && (!i_LONG || r_half);

  // Count up to terminal count, then restart at zero; the half flag marks the first of two periods.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N || i_CLR) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_half <= !o_BIT_END;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with runtime data length, stop-bit count and parity,
// plus a one-entry holding register for gapless back-to-back frames.
// Build option: define UART_TX_PARITY_EN to build the PARITY state and parity generator;
// otherwise i_CFG_PARITY is ignored and frames never carry a parity bit.
//
// state  | meaning
// IDLE   | line high, waiting for the holding register to fill
// START  | driving the start bit (0)
// DATA   | shifting out the snapshot data length, LSB first
// PARITY | driving the parity bit (UART_TX_PARITY_EN builds only)
// STOP   | driving one or two stop bits (1); relaunches if a byte is held
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT),
  parameter int DATA_W       = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic              i_TX_DV,
  output logic              o_TX_READY,
  input  logic [DATA_W-1:0] i_TX_DATA,
  input  logic [3:0]        i_CFG_DBITS,
  input  logic              i_CFG_STOP2,
  input  logic [1:0]        i_CFG_PARITY,
  output logic              o_TX_SERIAL,
  output logic              o_TX_ACTIVE,
  output logic              o_TX_START,
  output logic              o_TX_DONE
);

  uart_state_t       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hold_data, r_shift, w_shift_nxt;
  logic              r_hold_full;
  logic [3:0]        r_nbits, r_bit_idx, w_idx_nxt, w_dbits;
  logic              r_stop2;
  logic              r_serial, r_active, r_start, r_done;
  logic              w_launch, w_done_nxt, w_serial_nxt, w_accept, w_bit_end;

  assign w_accept    = i_TX_DV && !r_hold_full;
  assign w_dbits     = clamp_dbits(i_CFG_DBITS, DATA_W);
  assign o_TX_READY  = !r_hold_full;
  assign o_TX_SERIAL = r_serial;
  assign o_TX_ACTIVE = r_active;
  assign o_TX_START  = r_start;
  assign o_TX_DONE   = r_done;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .i_CLK     (i_CLK),
    .i_RST_N   (i_RST_N),
    .i_CLR     (r_state == IDLE),
    .i_LONG    ((r_state == STOP) && r_stop2),
    .o_BIT_END (w_bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en, r_par_bit, w_par_calc, w_par_en_cfg;

  assign w_par_en_cfg = (i_CFG_PARITY == PAR_EVEN) || (i_CFG_PARITY == PAR_ODD);

  // Parity over only the bits that will be sent, inverted for odd parity.
  always_comb begin
    w_par_calc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(w_dbits)) w_par_calc = w_par_calc ^ r_hold_data[i];
    end
    if (i_CFG_PARITY == PAR_ODD) w_par_calc = !w_par_calc;
  end

  // Parity mode and bit are snapshotted at launch alongside the data.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_launch) begin
      r_par_en  <= w_par_en_cfg;
      r_par_bit <= w_par_calc;
    end
  end
`else
  logic w_unused_parity;
  assign w_unused_parity = ^i_CFG_PARITY;
`endif

  // Next state, shift/index updates and the line level for the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_bit_idx;
    w_launch    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_launch    = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == r_nbits - 4'd1) begin
            w_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = r_par_en ? PARITY : STOP;
`else
            w_state_nxt = STOP;
`endif
          end else begin
            w_idx_nxt = r_bit_idx + 4'd1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          w_done_nxt = 1'b1;
          if (r_hold_full) begin
            w_launch    = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_launch) w_shift_nxt = r_hold_data;

    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_serial_nxt = 1'b0;
      DATA:    w_serial_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_serial_nxt = r_par_bit;
`endif
      default: w_serial_nxt = 1'b1;
    endcase
  end

  // State register with registered line and status outputs.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_nbits   <= '0;
      r_stop2   <= 1'b0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_idx_nxt;
      r_serial  <= w_serial_nxt;
      r_active  <= (w_state_nxt != IDLE);
      r_start   <= w_launch;
      r_done    <= w_done_nxt;
      if (w_launch) begin
        r_nbits <= w_dbits;
        r_stop2 <= i_CFG_STOP2;
      end
    end
  end

  // Holding register: filled on accept, emptied when its byte launches.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= i_TX_DATA;
    end else if (w_launch) begin
      r_hold_full <= 1'b0;
    end
  end

endmodule
